// File: rtl/clk_div_pkg.sv
// Shared types, defaults and load-clamp helpers for the multi-channel clock divider.
package clk_div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } chan_state_t;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_DIV_W  = 16;
  localparam int DEF_DIV_V  = 2;

  // A period of zero is meaningless, so it is promoted to one cycle.
  function automatic logic [31:0] clamp_div(input logic [31:0] div);
    return (div == 32'd0) ? 32'd1 : div;
  endfunction

  // High time can never exceed the (already clamped) period.
  function automatic logic [31:0] clamp_high(input logic [31:0] high, input logic [31:0] div);
    return (high > div) ? div : high;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: active/shadow period and high-time, wrap counter and
// IDLE/RUN/DRAIN state machine with registered clock and tick outputs.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int DIV_W   = DEF_DIV_W,
  parameter int DEF_DIV = DEF_DIV_V
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic             wr,
  input  logic [DIV_W-1:0] wr_div,
  input  logic [DIV_W-1:0] wr_high,
  output logic             pend,
  output logic             div_clk,
  output logic             tick
);

  localparam logic [DIV_W-1:0] RST_DIV  = DIV_W'(DEF_DIV);
  localparam logic [DIV_W-1:0] RST_HIGH = DIV_W'(DEF_DIV / 2);

  chan_state_t      state, state_nx;
  logic [DIV_W-1:0] div_q, high_q, div_s, high_s, cnt;
  logic [DIV_W-1:0] cnt_nx, div_nx, high_nx;
  logic [31:0]      div_c, high_c;
  logic             wrap, apply, tick_nx, clk_nx;

  // NOTE: every variable gets a default at the top of always_comb so that no
  // path leaves it unassigned; a missing default infers a latch.
  always_comb begin
    state_nx = state;
    cnt_nx   = '0;
    tick_nx  = 1'b0;
    apply    = 1'b0;
    wrap     = (cnt == div_q - DIV_W'(1));
    div_c    = clamp_div(32'(wr_div));
    high_c   = clamp_high(32'(wr_high), div_c);

    case (state)
      ST_IDLE: begin
        apply = pend;
        if (en) begin
          state_nx = ST_RUN;
          tick_nx  = 1'b1;
        end
      end
      ST_RUN, ST_DRAIN: begin
        if (sync) begin
          // A sync restarts running channels but cuts a draining one short.
          apply = pend;
          if (state == ST_RUN) begin
            tick_nx  = 1'b1;
            state_nx = en ? ST_RUN : ST_DRAIN;
          end else begin
            state_nx = ST_IDLE;
          end
        end else if (wrap) begin
          apply = pend;
          if (state == ST_RUN || en) begin
            tick_nx  = 1'b1;
            state_nx = en ? ST_RUN : ST_DRAIN;
          end else begin
            state_nx = ST_IDLE;
          end
        end else begin
          cnt_nx   = cnt + DIV_W'(1);
          state_nx = en ? ST_RUN : ST_DRAIN;
        end
      end
      default: state_nx = ST_IDLE;
    endcase

    div_nx  = apply ? div_s  : div_q;
    high_nx = apply ? high_s : high_q;
    clk_nx  = (state_nx != ST_IDLE) && (cnt_nx < high_nx);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      div_q   <= RST_DIV;
      high_q  <= RST_HIGH;
      div_s   <= RST_DIV;
      high_s  <= RST_HIGH;
      pend    <= 1'b0;
      div_clk <= 1'b0;
      tick    <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      div_q   <= div_nx;
      high_q  <= high_nx;
      div_clk <= clk_nx;
      tick    <= tick_nx;
      if (apply) begin
        pend <= 1'b0;
      end else if (wr && !pend) begin
        div_s  <= DIV_W'(div_c);
        high_s <= DIV_W'(high_c);
        pend   <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock divider: config demux, ready mux and one
// clk_div_chan instance per channel.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int NUM_CH  = DEF_NUM_CH,
  parameter int DIV_W   = DEF_DIV_W,
  parameter int DEF_DIV = DEF_DIV_V,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] i_en,
  input  logic              i_cfg_valid,
  output logic              o_cfg_ready,
  input  logic [CH_W-1:0]   i_cfg_ch,
  input  logic [DIV_W-1:0]  i_cfg_div,
  input  logic [DIV_W-1:0]  i_cfg_high,
  input  logic              i_sync,
  output logic [NUM_CH-1:0] o_clk,
  output logic [NUM_CH-1:0] o_tick
);

  logic [NUM_CH-1:0] pend;
  logic [31:0]       ch_idx;
  logic              ch_ok;

  // Writes to a non-existent channel are acknowledged and discarded.
  always_comb begin
    ch_idx      = 32'(i_cfg_ch);
    ch_ok       = (ch_idx < 32'(NUM_CH));
    o_cfg_ready = ch_ok ? !pend[i_cfg_ch] : 1'b1;
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic wr;
    assign wr = i_cfg_valid && o_cfg_ready && ch_ok && (ch_idx == 32'(g));

    clk_div_chan #(
      .DIV_W   (DIV_W),
      .DEF_DIV (DEF_DIV)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .en      (i_en[g]),
      .sync    (i_sync),
      .wr      (wr),
      .wr_div  (i_cfg_div),
      .wr_high (i_cfg_high),
      .pend    (pend[g]),
      .div_clk (o_clk[g]),
      .tick    (o_tick[g])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed self-checking bench for clk_div_multi (4 channels, DEF_DIV = 2).
module tb_clk_div_multi;

  localparam int NUM_CH = 4;
  localparam int DIV_W  = 16;
  localparam int CH_W   = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NUM_CH-1:0] i_en;
  logic              i_cfg_valid;
  logic              o_cfg_ready;
  logic [CH_W-1:0]   i_cfg_ch;
  logic [DIV_W-1:0]  i_cfg_div;
  logic [DIV_W-1:0]  i_cfg_high;
  logic              i_sync;
  logic [NUM_CH-1:0] o_clk;
  logic [NUM_CH-1:0] o_tick;

  int errors = 0;
  int checks = 0;

  clk_div_multi #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .DEF_DIV(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_en        (i_en),
    .i_cfg_valid (i_cfg_valid),
    .o_cfg_ready (o_cfg_ready),
    .i_cfg_ch    (i_cfg_ch),
    .i_cfg_div   (i_cfg_div),
    .i_cfg_high  (i_cfg_high),
    .i_sync      (i_sync),
    .o_clk       (o_clk),
    .o_tick      (o_tick)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  task automatic test_reset();
    rst = 1'b1; i_en = '0; i_cfg_valid = 1'b0; i_cfg_ch = '0;
    i_cfg_div = '0; i_cfg_high = '0; i_sync = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (o_clk !== 4'b0000) begin errors++; $display("FAIL reset_clk: got %b want 0000", o_clk); end
    checks++; if (o_tick !== 4'b0000) begin errors++; $display("FAIL reset_tick: got %b want 0000", o_tick); end
    checks++; if (o_cfg_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", o_cfg_ready); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (o_clk !== 4'b0000 || o_tick !== 4'b0000) begin
      errors++; $display("FAIL idle_after_reset: clk %b tick %b want 0000/0000", o_clk, o_tick);
    end
  endtask

  task automatic test_default_div();
    i_en[0] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++; if (o_clk[0] !== (i % 2 == 0)) begin errors++; $display("FAIL default_clk[%0d]: got %b want %b", i, o_clk[0], (i % 2 == 0)); end
      checks++; if (o_tick[0] !== (i % 2 == 0)) begin errors++; $display("FAIL default_tick[%0d]: got %b want %b", i, o_tick[0], (i % 2 == 0)); end
    end
  endtask

  task automatic test_reconfig();
    logic [13:0] exp_c = 14'b10101100011000;
    logic [13:0] exp_t = 14'b10101000010000;
    i_cfg_ch = 2'd1;
    i_en[1]  = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      checks++; if (o_clk[1] !== exp_c[13-i]) begin errors++; $display("FAIL reconfig_clk[%0d]: got %b want %b", i, o_clk[1], exp_c[13-i]); end
      checks++; if (o_tick[1] !== exp_t[13-i]) begin errors++; $display("FAIL reconfig_tick[%0d]: got %b want %b", i, o_tick[1], exp_t[13-i]); end
      case (i)
        1: begin
          checks++; if (o_cfg_ready !== 1'b1) begin errors++; $display("FAIL ready_before_write: got %b want 1", o_cfg_ready); end
          i_cfg_valid = 1'b1; i_cfg_div = 16'd5; i_cfg_high = 16'd2;
        end
        2: begin
          i_cfg_valid = 1'b0; #1;
          checks++; if (o_cfg_ready !== 1'b0) begin errors++; $display("FAIL ready_ch1_pending: got %b want 0", o_cfg_ready); end
          i_cfg_ch = 2'd2; i_cfg_div = 16'd6; i_cfg_high = 16'd3; i_cfg_valid = 1'b1; #1;
          checks++; if (o_cfg_ready !== 1'b1) begin errors++; $display("FAIL ready_ch2_free: got %b want 1", o_cfg_ready); end
        end
        3: begin
          i_cfg_valid = 1'b0; i_cfg_ch = 2'd1; #1;
          checks++; if (o_cfg_ready !== 1'b0) begin errors++; $display("FAIL ready_ch1_still_pending: got %b want 0", o_cfg_ready); end
        end
        4: begin
          checks++; if (o_cfg_ready !== 1'b1) begin errors++; $display("FAIL ready_ch1_after_wrap: got %b want 1", o_cfg_ready); end
        end
        default: ;
      endcase
    end
    i_en[1] = 1'b0;
  endtask

  task automatic test_clamps();
    i_cfg_ch = 2'd3; i_cfg_div = 16'd0; i_cfg_high = 16'd1; i_cfg_valid = 1'b1;
    @(negedge clk);
    i_cfg_valid = 1'b0; i_en[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (o_tick[3] !== 1'b1 || o_clk[3] !== 1'b1) begin
        errors++; $display("FAIL div0_clamp[%0d]: tick %b clk %b want 1/1", i, o_tick[3], o_clk[3]);
      end
    end
    i_cfg_div = 16'd4; i_cfg_high = 16'd9; i_cfg_valid = 1'b1;
    @(negedge clk);
    i_cfg_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++; if (o_tick[3] !== (i % 4 == 0)) begin errors++; $display("FAIL high_clamp_tick[%0d]: got %b want %b", i, o_tick[3], (i % 4 == 0)); end
      checks++; if (o_clk[3] !== 1'b1) begin errors++; $display("FAIL high_clamp_clk[%0d]: got %b want 1", i, o_clk[3]); end
      if (i == 6) begin i_cfg_high = 16'd0; i_cfg_valid = 1'b1; end
      if (i == 7) i_cfg_valid = 1'b0;
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++; if (o_tick[3] !== (i % 4 == 0)) begin errors++; $display("FAIL high0_tick[%0d]: got %b want %b", i, o_tick[3], (i % 4 == 0)); end
      checks++; if (o_clk[3] !== 1'b0) begin errors++; $display("FAIL high0_clk[%0d]: got %b want 0", i, o_clk[3]); end
    end
  endtask

  task automatic test_drain();
    logic [9:0] exp_c = 10'b1110000000;
    logic [9:0] exp_t = 10'b1000000000;
    logic [9:0] re_c  = 10'b1110001110;
    logic [9:0] re_t  = 10'b1000001000;
    i_en[2] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++; if (o_clk[2] !== exp_c[9-i]) begin errors++; $display("FAIL drain_clk[%0d]: got %b want %b", i, o_clk[2], exp_c[9-i]); end
      checks++; if (o_tick[2] !== exp_t[9-i]) begin errors++; $display("FAIL drain_tick[%0d]: got %b want %b", i, o_tick[2], exp_t[9-i]); end
      if (i == 1) i_en[2] = 1'b0;
    end
    i_en[2] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++; if (o_clk[2] !== re_c[9-i]) begin errors++; $display("FAIL redrain_clk[%0d]: got %b want %b", i, o_clk[2], re_c[9-i]); end
      checks++; if (o_tick[2] !== re_t[9-i]) begin errors++; $display("FAIL redrain_tick[%0d]: got %b want %b", i, o_tick[2], re_t[9-i]); end
      if (i == 1) i_en[2] = 1'b0;
      if (i == 2) i_en[2] = 1'b1;
    end
  endtask

  task automatic test_sync();
    i_en[3:2] = 2'b00;
    @(negedge clk);
    i_sync = 1'b1;
    @(negedge clk);
    i_sync = 1'b0;
    checks++; if (o_clk[3:2] !== 2'b00 || o_tick[3:2] !== 2'b00) begin
      errors++; $display("FAIL sync_drain_idle: clk %b tick %b want 00/00", o_clk[3:2], o_tick[3:2]);
    end
    i_cfg_ch = 2'd3; i_cfg_div = 16'd4; i_cfg_high = 16'd2; i_cfg_valid = 1'b1;
    @(negedge clk);
    i_cfg_valid = 1'b0; i_en[2] = 1'b1;
    @(negedge clk);
    i_en[3] = 1'b1;
    @(negedge clk);
    checks++; if (o_tick[3:2] !== 2'b10) begin errors++; $display("FAIL out_of_phase: got %b want 10", o_tick[3:2]); end
    repeat (2) @(negedge clk);
    i_sync = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) i_sync = 1'b0;
      checks++; if (o_tick[3:2] !== {(i % 4 == 0), (i % 6 == 0)} || o_clk[3:2] !== {(i % 4 < 2), (i % 6 < 3)}) begin
        errors++; $display("FAIL sync_align[%0d]: tick %b clk %b", i, o_tick[3:2], o_clk[3:2]);
      end
      if (i == 3) i_sync = 1'b1;
    end
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      if (j == 0) i_sync = 1'b0;
      checks++; if (o_tick[3:2] !== {(j % 4 == 0), (j % 6 == 0)} || o_clk[3:2] !== {(j % 4 < 2), (j % 6 < 3)}) begin
        errors++; $display("FAIL sync_wrap[%0d]: tick %b clk %b", j, o_tick[3:2], o_clk[3:2]);
      end
    end
  endtask

  task automatic test_reset_mid();
    i_cfg_ch = 2'd2; i_cfg_div = 16'd3; i_cfg_high = 16'd1; i_cfg_valid = 1'b1;
    @(negedge clk);
    i_cfg_valid = 1'b0; #1;
    checks++; if (o_cfg_ready !== 1'b0) begin errors++; $display("FAIL mid_pending: got %b want 0", o_cfg_ready); end
    #1 rst = 1'b1;
    #1;
    checks++; if (o_clk !== 4'b0000) begin errors++; $display("FAIL async_clk: got %b want 0000", o_clk); end
    checks++; if (o_tick !== 4'b0000) begin errors++; $display("FAIL async_tick: got %b want 0000", o_tick); end
    checks++; if (o_cfg_ready !== 1'b1) begin errors++; $display("FAIL async_pend_clear: got %b want 1", o_cfg_ready); end
    i_en = '0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (o_clk !== 4'b0000 || o_tick !== 4'b0000) begin
      errors++; $display("FAIL post_reset_idle: clk %b tick %b want 0000/0000", o_clk, o_tick);
    end
    i_en[2] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++; if (o_clk[2] !== (i % 2 == 0) || o_tick[2] !== (i % 2 == 0)) begin
        errors++; $display("FAIL post_reset_div[%0d]: clk %b tick %b want %b", i, o_clk[2], o_tick[2], (i % 2 == 0));
      end
    end
  endtask

  initial begin
    test_reset();
    test_default_div();
    test_reconfig();
    test_clamps();
    test_drain();
    test_sync();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clk_div_multi.md
# clk_div_multi

Multi-channel, runtime-programmable clock divider; successor to the fixed single-output divider. Produces NUM_CH independent divided clocks with programmable period and high time, a per-channel period-start strobe, glitch-free reconfiguration at period boundaries, drain-to-idle on disable, and a global phase-align restart. It sits between the system clock and low-rate peripherals (UART, I2C, PWM, LED scan) that need enables or slow clocks derived from `clk`.

## Interface

Parameters:
- `NUM_CH`, 4: number of independent channels (>= 1).
- `DIV_W`, 16: width of the period and high-time values.
- `DEF_DIV`, 2: period loaded at reset into every channel (1 .. 2^DIV_W-1).

Ports:
- `clk`  in  1: system clock.
- `rst`  in  1: reset, asynchronous, active-high.
- `i_en`  in  NUM_CH: per-channel run request, level.
- `i_cfg_valid`  in  1: config write request.
- `o_cfg_ready`  out  1: config write accepted this cycle when high with `i_cfg_valid`.
- `i_cfg_ch`  in  max(1,$clog2(NUM_CH)): target channel.
- `i_cfg_div`  in  DIV_W: new period in `clk` cycles.
- `i_cfg_high`  in  DIV_W: new high time in `clk` cycles.
- `i_sync`  in  1: single-cycle restart pulse for all running channels.
- `o_clk`  out  NUM_CH: divided clocks, registered.
- `o_tick`  out  NUM_CH: one-cycle strobe, high in the first cycle of each period, registered.

## Operation

- Per channel: active regs `div_q`, `high_q`; shadow regs `div_s`, `high_s`; flag `pend`; counter `cnt` (DIV_W bits); state IDLE / RUN / DRAIN.
- Load clamps: stored div = max(`i_cfg_div`, 1); stored high = min(`i_cfg_high`, stored div). high = 0 gives `o_clk` constant 0 with ticks still produced; high = div gives constant 1.
- Config handshake: `o_cfg_ready` = !`pend`[`i_cfg_ch`] (combinational). On accept, shadow <= clamped values, `pend` <= 1. `i_cfg_ch` >= NUM_CH: ready high, write dropped.
- Pending apply: in IDLE, applied on the next edge. In RUN, applied at the wrap edge or on `i_sync`. Never applied mid-period, so there are no runt pulses.
- IDLE: `cnt` = 0, `o_clk` = 0, `o_tick` = 0. When `i_en` is sampled high: go to RUN, `cnt` <= 0, `o_tick` <= 1, `o_clk` <= (0 < high).
- RUN: if `cnt` == div-1, wrap: `cnt` <= 0, `o_tick` <= 1, apply pending. Otherwise `cnt` <= `cnt`+1, `o_tick` <= 0. In all cases `o_clk` <= (`cnt_next` < `high_next`). `i_en` low goes to DRAIN.
- DRAIN: counts as in RUN. At the wrap edge it goes to IDLE (`o_clk` <= 0, no tick, pending applied) rather than restarting. `i_en` re-asserted in DRAIN returns to RUN with no phase disturbance.
- `i_sync`: RUN channels restart as a wrap (`cnt` 0, tick, pending applied). DRAIN channels go to IDLE immediately. IDLE channels are unaffected. `i_sync` has priority over a natural wrap in the same cycle.

## Timing

- Reset: all channels IDLE, `cnt` = 0, `div_q` = `div_s` = DEF_DIV, `high_q` = `high_s` = DEF_DIV/2, `pend` = 0. `o_clk` = 0, `o_tick` = 0, `o_cfg_ready` = 1.
- Reset mid-operation: outputs drop to 0 asynchronously, and pending writes are discarded.
- Start latency: `i_en` sampled high at edge N gives `o_tick` = 1 and the first `o_clk` level after edge N. The period is exactly div cycles from then on, with high exactly `high_q` cycles.
- Config: a write accepted at edge N in IDLE is active after edge N+1. In RUN it is active from the first wrap edge after N.
- div = 1: `o_tick` is high every cycle, and `o_clk` = 1 if high >= 1.
- Throughput: one config write per cycle, across different channels.

## Structure

- Package `clk_div_pkg`: channel state enum (IDLE, RUN, DRAIN), clamp function for div/high, default-value constants.
- Sub-module `clk_div_chan`: one channel (counter, shadow regs, FSM). The top generates NUM_CH instances and does config demux and ready mux.

## Test plan

- Reset defaults (DEF_DIV=2): raise `i_en`[0] -> `o_clk`[0] = 1,0,1,0…, `o_tick`[0] every 2 cycles, and the first tick the cycle after `i_en` is sampled.
- Program ch1 div=5 high=2 while running div=2 -> old period completes unaltered. Then `o_clk` = 1,1,0,0,0 repeating, with a tick each 5 cycles. `o_cfg_ready` is low for ch1 until the wrap while ch2 writes are still accepted.
- Clamps: div=0 -> behaves as div=1, tick every cycle. high=9 with div=4 -> `o_clk` constant 1. high=0 -> `o_clk` 0 with ticks every div.
- Drop `i_en`[2] at `cnt`=1 of div=6 -> the channel finishes cycles 2..5 and goes IDLE with `o_clk` 0 and no further tick. Re-assert during drain -> seamless continuation.
- Two channels div=4 and div=6, out of phase, pulse `i_sync` -> both tick on the next cycle and are phase-aligned. A simultaneous natural wrap produces a single tick.
- Assert `rst` mid-period with a pending write -> outputs 0 immediately. After release, `div_q` = DEF_DIV, `pend` clear, all channels IDLE.
